// File: rtl/axi_mem_responder.sv
// AXI4 subordinate memory model: word-addressed array serving INCR write and read
// bursts through independent write/read FSMs, one transaction outstanding each.
module axi_mem_responder #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    slv_aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   slv_aw_addr_i,
  input  logic [7:0]              slv_aw_len_i,
  input  logic [2:0]              slv_aw_size_i,
  input  logic [ID_WIDTH-1:0]     slv_aw_id_i,
  output logic                    slv_aw_ready_o,
  input  logic                    slv_w_valid_i,
  input  logic [DATA_WIDTH-1:0]   slv_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] slv_w_strb_i,
  input  logic                    slv_w_last_i,
  output logic                    slv_w_ready_o,
  output logic                    slv_b_valid_o,
  output logic [1:0]              slv_b_resp_o,
  output logic [ID_WIDTH-1:0]     slv_b_id_o,
  input  logic                    slv_b_ready_i,
  input  logic                    slv_ar_valid_i,
  input  logic [ADDR_WIDTH-1:0]   slv_ar_addr_i,
  input  logic [7:0]              slv_ar_len_i,
  input  logic [2:0]              slv_ar_size_i,
  input  logic [ID_WIDTH-1:0]     slv_ar_id_i,
  output logic                    slv_ar_ready_o,
  output logic                    slv_r_valid_o,
  output logic [DATA_WIDTH-1:0]   slv_r_data_o,
  output logic [1:0]              slv_r_resp_o,
  output logic                    slv_r_last_o,
  output logic [ID_WIDTH-1:0]     slv_r_id_o,
  input  logic                    slv_r_ready_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> OFF) >= ADDR_WIDTH'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> OFF);
  endfunction

  // The beat count alone terminates a write burst; the master's last flag is advisory.
  logic unused_w_last;
  assign unused_w_last = slv_w_last_i;

  // ---------------- write channel ----------------
  w_state_e              w_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_len, wr_beat;
  logic [2:0]            wr_size;
  logic [ID_WIDTH-1:0]   wr_id;
  logic                  wr_err;
  logic                  aw_hs, w_hs, wr_oob;

  always_comb begin
    w_state_nxt    = w_state;
    slv_aw_ready_o = 1'b0;
    slv_w_ready_o  = 1'b0;
    slv_b_valid_o  = 1'b0;
    case (w_state)
      W_IDLE: begin
        slv_aw_ready_o = 1'b1;
        if (slv_aw_valid_i) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        slv_w_ready_o = 1'b1;
        if (slv_w_valid_i && wr_beat == wr_len) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        slv_b_valid_o = 1'b1;
        if (slv_b_ready_i) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs        = slv_aw_ready_o && slv_aw_valid_i;
  assign w_hs         = slv_w_ready_o && slv_w_valid_i;
  assign wr_oob       = out_of_range(wr_addr);
  assign slv_b_resp_o = wr_err ? RESP_SLVERR : RESP_OKAY;
  assign slv_b_id_o   = wr_id;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state <= W_IDLE;
      wr_addr <= '0;
      wr_len  <= '0;
      wr_beat <= '0;
      wr_size <= '0;
      wr_id   <= '0;
      wr_err  <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        wr_addr <= slv_aw_addr_i;
        wr_len  <= slv_aw_len_i;
        wr_size <= slv_aw_size_i;
        wr_id   <= slv_aw_id_i;
        wr_beat <= '0;
        wr_err  <= 1'b0;
      end else if (w_hs) begin
        wr_addr <= wr_addr + (ADDR_WIDTH'(1) << wr_size);
        wr_beat <= wr_beat + 8'd1;
        if (wr_oob) wr_err <= 1'b1;
      end
    end
  end

  // Array is never cleared; a beat landing in the reset cycle is not committed.
  always_ff @(posedge clk_i) begin
    if (w_hs && !rst_i && !wr_oob) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (slv_w_strb_i[b]) mem[word_idx(wr_addr)][8*b +: 8] <= slv_w_data_i[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state, r_state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_fetch;
  logic [7:0]            rd_len, rd_beat;
  logic [2:0]            rd_size;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;
  logic                  rd_last;
  logic                  ar_hs, r_hs, rd_load;

  always_comb begin
    r_state_nxt    = r_state;
    slv_ar_ready_o = 1'b0;
    slv_r_valid_o  = 1'b0;
    case (r_state)
      R_IDLE: begin
        slv_ar_ready_o = 1'b1;
        if (slv_ar_valid_i) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        slv_r_valid_o = 1'b1;
        if (slv_r_ready_i && rd_last) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs    = slv_ar_ready_o && slv_ar_valid_i;
  assign r_hs     = slv_r_valid_o && slv_r_ready_i;
  // Next beat is fetched on the address handshake or when the current beat is taken.
  assign rd_load  = ar_hs || (r_hs && !rd_last);
  assign rd_fetch = ar_hs ? slv_ar_addr_i : rd_addr + (ADDR_WIDTH'(1) << rd_size);

  assign slv_r_data_o = rd_data;
  assign slv_r_resp_o = rd_resp;
  assign slv_r_last_o = rd_last;
  assign slv_r_id_o   = rd_id;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= R_IDLE;
      rd_addr <= '0;
      rd_len  <= '0;
      rd_beat <= '0;
      rd_size <= '0;
      rd_id   <= '0;
      rd_data <= '0;
      rd_resp <= RESP_OKAY;
      rd_last <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        rd_len  <= slv_ar_len_i;
        rd_size <= slv_ar_size_i;
        rd_id   <= slv_ar_id_i;
        rd_beat <= '0;
        rd_last <= (slv_ar_len_i == 8'd0);
      end else if (r_hs) begin
        rd_beat <= rd_beat + 8'd1;
        rd_last <= !rd_last && (rd_beat + 8'd1 == rd_len);
      end
      if (rd_load) begin
        rd_addr <= rd_fetch;
        // Same-cycle write to this word is not visible: the array read sees pre-write data.
        if (out_of_range(rd_fetch)) begin
          rd_data <= '0;
          rd_resp <= RESP_SLVERR;
        end else begin
          rd_data <= mem[word_idx(rd_fetch)];
          rd_resp <= RESP_OKAY;
        end
      end
    end
  end

endmodule
